// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared CPU-wide types: the machine word and the RAM status codes
// returned by the memory model.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // RAM status as reported by the memory model each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/dp_types_pkg.sv
// dp_types_pkg
// Datapath-local types. Holds the memory arbiter state encoding.
package dp_types_pkg;

    // Arbiter ownership of the single RAM port.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_I    = 2'b01,
        ARB_D    = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundle of every signal between the instruction cache, the data cache,
// the memory arbiter and the RAM model.
// Modports:
//   arb    - the arbiter itself
//   icache - instruction-fetch requester
//   dcache - data-memory requester
//   ram    - RAM model
//   tb     - testbench driving both requesters and the RAM side
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport icache (
        output iREN, iaddr,
        input  iwait, iload
    );

    modport dcache (
        output dREN, dWEN, daddr, dstore,
        input  dwait, dload
    );

    modport ram (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt
// Saturating up-counter that tracks how many data grants in a row were
// issued while an instruction fetch was left waiting.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears the count
//   inc   - count one more grant (ignored once saturated)
//   clr   - clear the count (wins over inc)
//   sat   - count has reached MAX
module arb_starve_cnt #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != MAX_V)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign sat = (cnt_reg == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single RAM port between instruction fetch and data memory.
// Data requests win, except when STARVE_MAX data grants in a row have
// been issued while a fetch was waiting; then the fetch is forced.
// A grant is held until RAM reports ACCESS or the owner withdraws, and
// every grant is followed by one ARB_IDLE cycle.
// Ports:
//   CLK, nRST                 - clock, asynchronous active-low reset
//   iREN, iaddr / iwait, iload - instruction-fetch request / response
//   dREN, dWEN, daddr, dstore / dwait, dload - data request / response
//   ramREN, ramWEN, ramaddr, ramstore - RAM command (combinational)
//   ramload, ramstate          - RAM read data and status
module mem_arbiter
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    arb_state_t state_reg;
    arb_state_t state_next;

    logic dreq;
    logic ram_done;
    logic go_i;
    logic go_d;
    logic starve_inc;
    logic starve_clr;
    logic starve_sat;

    assign dreq     = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS);

    // Next-state logic. BUSY and ERROR simply leave the grant in place so
    // the strobes stay up and the access is retried.
    always_comb begin
        state_next = state_reg;
        go_i       = 1'b0;
        go_d       = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (dreq && (!iREN || !starve_sat)) begin
                    state_next = ARB_D;
                    go_d       = 1'b1;
                end else if (iREN) begin
                    state_next = ARB_I;
                    go_i       = 1'b1;
                end
            end
            ARB_I: begin
                if (ram_done || !iREN) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_D: begin
                if (ram_done || !dreq) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Only data grants that bypass a waiting fetch count toward starvation.
    // An idle cycle with no fetch pending means nobody is being starved.
    assign starve_inc = go_d & iREN;
    assign starve_clr = go_i | ((state_reg == ARB_IDLE) & ~iREN);

    arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );

    // RAM port muxing. Strobes are gated by the owner's live request so a
    // withdrawal drops them in the same cycle; reset forces ARB_IDLE, which
    // drops them without waiting for a clock edge.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        case (state_reg)
            ARB_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
            end
            ARB_D: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
            end
            default: ;
        endcase
    end

    assign iwait = iREN & ~((state_reg == ARB_I) & ram_done);
    assign dwait = dreq & ~((state_reg == ARB_D) & ram_done);

endmodule
